// File: rtl/nibble_serial_alu_pkg.sv
// alu_pkg: shared definitions for the nibble-serial ALU sequencer.
//   - mc10181 function-select codes, written S3..S0 left to right so they
//     land on a [0:3] select bus with s[0] = S3
//   - FSM state enum and the latched-operation struct
//   - NIBBLE_W, the slice width
package alu_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [0:NIBBLE_W-1] nibble_t;
    typedef logic [0:3]          fsel_t;

    // Arithmetic mode (boole = 0); cin is the active-high carry in.
    localparam fsel_t FS_PASS_A    = 4'b0000; // A (plus cin)
    localparam fsel_t FS_A_PLUS_B  = 4'b1001; // A plus B (plus cin)
    localparam fsel_t FS_A_MINUS_B = 4'b0110; // A minus B minus 1 (plus cin)
    localparam fsel_t FS_MINUS_1   = 4'b0011; // all ones (plus cin)

    // Boolean mode (boole = 1); carry is still produced but does not affect f.
    localparam fsel_t FS_NOT_A = 4'b0000;
    localparam fsel_t FS_XOR   = 4'b0110;
    localparam fsel_t FS_XNOR  = 4'b1001;
    localparam fsel_t FS_B     = 4'b1010;
    localparam fsel_t FS_AND   = 4'b1011;
    localparam fsel_t FS_ONES  = 4'b1100;
    localparam fsel_t FS_OR    = 4'b1110;
    localparam fsel_t FS_A     = 4'b1111;
    localparam fsel_t FS_ZERO  = 4'b0011;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        fsel_t s;
        logic  boole;
    } op_t;

endpackage

// File: rtl/mc10181.sv
// mc10181: 4-bit ALU slice, positive logic, active-high carries.
//   s[0:3]  function select, s[0] = S3 ... s[3] = S0
//   m       1 = boolean mode, 0 = arithmetic mode
//   a, b    operand nibbles, bit 0 most significant
//   cin     carry into bit 3
//   f       result nibble
//   cout    carry out of bit 0 (computed in both modes)
//   cg, cp  group generate / propagate for lookahead
module mc10181 (
    input  logic [0:3] s,
    input  logic       m,
    input  logic [0:3] a,
    input  logic [0:3] b,
    input  logic       cin,
    output logic [0:3] f,
    output logic       cout,
    output logic       cg,
    output logic       cp
);

    logic [0:3] p, g, h, c;

    // Per-bit operand terms: the slice adds p and g. g is always a subset
    // of p, so g doubles as the bit generate and p as the bit propagate.
    assign p = a | (b & {4{s[3]}}) | (~b & {4{s[2]}});
    assign g = (a & ~b & {4{s[1]}}) | (a & b & {4{s[0]}});
    assign h = p ^ g;

    // Lookahead carries into each bit; bit 3 is the least significant.
    assign c[3] = cin;
    assign c[2] = g[3] | (p[3] & cin);
    assign c[1] = g[2] | (p[2] & g[3]) | (p[2] & p[3] & cin);
    assign c[0] = g[1] | (p[1] & g[2]) | (p[1] & p[2] & g[3])
                | (p[1] & p[2] & p[3] & cin);

    assign cg   = g[0] | (p[0] & g[1]) | (p[0] & p[1] & g[2])
                | (p[0] & p[1] & p[2] & g[3]);
    assign cp   = &p;
    assign cout = cg | (cp & cin);

    // Boolean mode inhibits the internal carries and complements the half sum.
    assign f = m ? ~h : (h ^ c);

endmodule

// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: drives one mc10181 slice NIBBLES times per operation,
// least-significant nibble first, rippling the carry through a register.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_s, req_boole         slice function select and mode, held per op
//   req_cin                  carry into the least-significant nibble
//   req_a, req_b             operands, bit 0 is the MSB
//   rsp_valid / rsp_ready    response handshake (valid only in DONE)
//   rsp_f, rsp_cout          result and final slice carry
//   rsp_zero                 rsp_f is all zeros
module nibble_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [0:3]       req_s,
    input  logic             req_boole,
    input  logic             req_cin,
    input  logic [0:WIDTH-1] req_a,
    input  logic [0:WIDTH-1] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [0:WIDTH-1] rsp_f,
    output logic             rsp_cout,
    output logic             rsp_zero
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // Element 0 is the most-significant nibble, matching the [0:WIDTH-1] ports.
    typedef logic [0:NIBBLES-1][0:NIBBLE_W-1] word_t;

    state_t           state;
    op_t              op_q;
    word_t            a_q, b_q, res_q, res_nxt;
    logic             carry_q, zero_q;
    logic [IDX_W-1:0] idx;

    nibble_t          slice_f;
    logic             slice_cout;
    logic             unused_cg, unused_cp;

    mc10181 u_slice (
        .s    (op_q.s),
        .m    (op_q.boole),
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .f    (slice_f),
        .cout (slice_cout),
        .cg   (unused_cg),
        .cp   (unused_cp)
    );

    // Result with the current nibble merged in; lets the zero flag be
    // registered on the same edge that writes the last nibble.
    always_comb begin
        res_nxt      = res_q;
        res_nxt[idx] = slice_f;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q.s     <= req_s;
                        op_q.boole <= req_boole;
                        a_q        <= req_a;
                        b_q        <= req_b;
                        carry_q    <= req_cin;
                        idx        <= IDX_W'(NIBBLES - 1);
                        res_q      <= '0;
                        zero_q     <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_nxt;
                    carry_q <= slice_cout;
                    if (idx == '0) begin
                        zero_q <= ~|res_nxt;
                        state  <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_f     = res_q;
    assign rsp_cout  = carry_q;
    assign rsp_zero  = zero_q;

endmodule
